// File: rtl/uart_param_core.sv
// Parametrised full-duplex UART: configurable width, parity, stop bits and RX oversampling.
// TX and RX are independent FSMs sharing only clock and reset.
module uart_param_core #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 busy,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 valid_rx,
    output logic                 stop_error,
    output logic                 parity_error
);

    localparam int BIT_CLKS   = CLK_FREQ / BAUD;
    localparam int DIV        = BIT_CLKS / OVERSAMPLE;
    localparam bit HAS_PARITY = (PARITY != 0);

    localparam int TX_CNT_W = $clog2(STOP_BITS * BIT_CLKS);
    localparam int BIDX_W   = $clog2(DATA_BITS);
    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TK_W     = $clog2(OVERSAMPLE);

    localparam logic [TX_CNT_W-1:0] TX_BIT_LAST  = TX_CNT_W'(BIT_CLKS - 1);
    localparam logic [TX_CNT_W-1:0] TX_STOP_LAST = TX_CNT_W'(STOP_BITS * BIT_CLKS - 1);
    localparam logic [BIDX_W-1:0]   BIDX_LAST    = BIDX_W'(DATA_BITS - 1);
    localparam logic [DIV_W-1:0]    DIV_LAST     = DIV_W'(DIV - 1);
    localparam logic [TK_W-1:0]     TK_HALF      = TK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TK_W-1:0]     TK_FULL      = TK_W'(OVERSAMPLE - 1);
    localparam logic                STOP_IDX_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------- TX ----------------
    state_t                tx_state, tx_state_n;
    logic [TX_CNT_W-1:0]   tx_cnt;
    logic [BIDX_W-1:0]     tx_bit;
    logic [DATA_BITS-1:0]  tx_shreg;
    logic                  tx_par;
    logic                  tx_last;

    // The stop phase is one long state covering all stop bits.
    assign tx_last = (tx_cnt == ((tx_state == S_STOP) ? TX_STOP_LAST : TX_BIT_LAST));

    always_comb begin
        tx_state_n = tx_state;
        case (tx_state)
            S_IDLE:   if (tx_start) tx_state_n = S_START;
            S_START:  if (tx_last) tx_state_n = S_DATA;
            S_DATA:   if (tx_last && tx_bit == BIDX_LAST)
                          tx_state_n = HAS_PARITY ? S_PARITY : S_STOP;
            S_PARITY: if (tx_last) tx_state_n = S_STOP;
            S_STOP:   if (tx_last) tx_state_n = S_IDLE;
            default:  tx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= (tx_state == S_IDLE || tx_last) ? '0 : tx_cnt + 1'b1;
            case (tx_state)
                S_IDLE: if (tx_start) begin
                    tx_shreg <= tx_data;
                    tx_par   <= (PARITY == 1) ? ~(^tx_data) : ^tx_data;
                    tx_bit   <= '0;
                    tx       <= 1'b0;
                    busy     <= 1'b1;
                end
                S_START: if (tx_last) tx <= tx_shreg[0];
                S_DATA: if (tx_last) begin
                    if (tx_bit == BIDX_LAST) begin
                        tx <= HAS_PARITY ? tx_par : 1'b1;
                    end else begin
                        tx_shreg <= tx_shreg >> 1;
                        tx       <= tx_shreg[1];
                        tx_bit   <= tx_bit + 1'b1;
                    end
                end
                S_PARITY: if (tx_last) tx <= 1'b1;
                S_STOP:   if (tx_last) busy <= 1'b0;
                default:  ;
            endcase
        end
    end

    // ---------------- RX ----------------
    state_t                rx_state, rx_state_n;
    logic                  rx_meta, rx_sync, rx_prev;
    logic [DIV_W-1:0]      div_cnt;
    logic                  rx_tick, rx_fall, rx_samp, rx_done;
    logic [TK_W-1:0]       rx_tk;
    logic [BIDX_W-1:0]     rx_bit;
    logic                  rx_stop_idx;
    logic [DATA_BITS-1:0]  rx_shreg;
    logic                  rx_par, rx_par_bad, rx_stop_bad;

    assign rx_tick = (div_cnt == DIV_LAST);
    // Edge-based start detection also keeps a stuck-low line from retriggering.
    assign rx_fall = rx_prev & ~rx_sync;
    assign rx_samp = rx_tick && (rx_tk == ((rx_state == S_START) ? TK_HALF : TK_FULL));
    assign rx_done = (rx_state == S_STOP) && rx_samp && (rx_stop_idx == STOP_IDX_LAST);

    always_comb begin
        rx_state_n = rx_state;
        case (rx_state)
            S_IDLE:   if (rx_fall) rx_state_n = S_START;
            S_START:  if (rx_samp) rx_state_n = rx_sync ? S_IDLE : S_DATA;
            S_DATA:   if (rx_samp && rx_bit == BIDX_LAST)
                          rx_state_n = HAS_PARITY ? S_PARITY : S_STOP;
            S_PARITY: if (rx_samp) rx_state_n = S_STOP;
            S_STOP:   if (rx_done) rx_state_n = S_IDLE;
            default:  rx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_prev      <= 1'b1;
            div_cnt      <= '0;
            rx_state     <= S_IDLE;
            rx_tk        <= '0;
            rx_bit       <= '0;
            rx_stop_idx  <= 1'b0;
            rx_shreg     <= '0;
            rx_par       <= 1'b0;
            rx_par_bad   <= 1'b0;
            rx_stop_bad  <= 1'b0;
            rx_data      <= '0;
            valid_rx     <= 1'b0;
            stop_error   <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            div_cnt  <= rx_tick ? '0 : div_cnt + 1'b1;
            rx_state <= rx_state_n;
            valid_rx <= rx_done;
            if (rx_state == S_IDLE)
                rx_tk <= '0;
            else if (rx_tick)
                rx_tk <= rx_samp ? '0 : rx_tk + 1'b1;
            case (rx_state)
                S_IDLE: begin
                    rx_bit      <= '0;
                    rx_stop_idx <= 1'b0;
                    rx_par      <= 1'b0;
                    rx_par_bad  <= 1'b0;
                    rx_stop_bad <= 1'b0;
                end
                S_DATA: if (rx_samp) begin
                    rx_shreg <= {rx_sync, rx_shreg[DATA_BITS-1:1]};
                    rx_par   <= rx_par ^ rx_sync;
                    rx_bit   <= rx_bit + 1'b1;
                end
                S_PARITY: if (rx_samp)
                    rx_par_bad <= rx_sync != ((PARITY == 1) ? ~rx_par : rx_par);
                S_STOP: if (rx_samp) begin
                    rx_stop_idx <= rx_stop_idx + 1'b1;
                    rx_stop_bad <= rx_stop_bad | ~rx_sync;
                    if (rx_done) begin
                        rx_data      <= rx_shreg;
                        stop_error   <= rx_stop_bad | ~rx_sync;
                        parity_error <= rx_par_bad;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_param_core.sv
// Directed bench for uart_param_core: three configurations (8N1, 7E2, 8O1) at 16 clocks per bit.
module tb_uart_param_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // DUT A: 8N1, loopback or driven rx
    logic       loop_a = 1'b1;
    logic       rx_drv = 1'b1;
    logic       tx_start_a = 1'b0;
    logic [7:0] tx_data_a = '0;
    logic       tx_a, busy_a, rx_a, valid_a, stop_err_a, par_err_a;
    logic [7:0] rx_data_a;
    assign rx_a = loop_a ? tx_a : rx_drv;

    // DUT B: 7E2 loopback
    logic       tx_start_b = 1'b0;
    logic [6:0] tx_data_b = '0;
    logic       tx_b, busy_b, valid_b, stop_err_b, par_err_b;
    logic [6:0] rx_data_b;

    // DUT C: 8O1 driven rx
    logic       tx_c, busy_c, valid_c, stop_err_c, par_err_c;
    logic [7:0] rx_data_c;

    uart_param_core #(.CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16)) u_a (
        .clk(clk), .rst(rst), .tx_start(tx_start_a), .tx_data(tx_data_a), .tx(tx_a), .busy(busy_a),
        .rx(rx_a), .rx_data(rx_data_a), .valid_rx(valid_a), .stop_error(stop_err_a),
        .parity_error(par_err_a));

    uart_param_core #(.CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16), .DATA_BITS(7),
                      .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .rst(rst), .tx_start(tx_start_b), .tx_data(tx_data_b), .tx(tx_b), .busy(busy_b),
        .rx(tx_b), .rx_data(rx_data_b), .valid_rx(valid_b), .stop_error(stop_err_b),
        .parity_error(par_err_b));

    uart_param_core #(.CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16), .PARITY(1)) u_c (
        .clk(clk), .rst(rst), .tx_start(1'b0), .tx_data(8'h00), .tx(tx_c), .busy(busy_c),
        .rx(rx_drv), .rx_data(rx_data_c), .valid_rx(valid_c), .stop_error(stop_err_c),
        .parity_error(par_err_c));

    int vcnt_a = 0, vcnt_b = 0, vcnt_c = 0;
    always @(negedge clk) begin
        if (valid_a) vcnt_a++;
        if (valid_b) vcnt_b++;
        if (valid_c) vcnt_c++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_a(input logic [7:0] data);
        @(negedge clk);
        tx_start_a = 1'b1;
        tx_data_a  = data;
        @(negedge clk);
        tx_start_a = 1'b0;
    endtask

    // Counts busy cycles and the initial tx-low run; optionally pulses tx_start mid-frame.
    task automatic measure_a(input int pulse_at, output int low_run, output int busy_n);
        bit in_low = 1'b1;
        low_run = 0;
        busy_n  = 0;
        while (busy_a && busy_n < 1000) begin
            if (in_low && !tx_a) low_run++;
            else in_low = 1'b0;
            if (busy_n == pulse_at) begin
                tx_start_a = 1'b1;
                tx_data_a  = 8'hFF;
            end else begin
                tx_start_a = 1'b0;
            end
            busy_n++;
            @(negedge clk);
        end
        tx_start_a = 1'b0;
    endtask

    task automatic send_rx(input logic [8:0] data, input int nbits, input bit with_par,
                           input logic par_bit, input logic stop_val);
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx_drv = data[i];
            repeat (16) @(negedge clk);
        end
        if (with_par) begin
            rx_drv = par_bit;
            repeat (16) @(negedge clk);
        end
        rx_drv = stop_val;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        int low_run, busy_n, v0, par_tx;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_tx", tx_a, 1);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_rx_data", rx_data_a, 0);
        check_eq("rst_valid", valid_a, 0);
        check_eq("rst_stop_err", stop_err_a, 0);
        check_eq("rst_par_err", par_err_a, 0);

        // 1: 8N1 loopback 0xA5
        v0 = vcnt_a;
        start_a(8'hA5);
        measure_a(-1, low_run, busy_n);
        check_eq("t1_start_low", low_run, 16);
        check_eq("t1_busy_len", busy_n, 160);
        repeat (5) @(negedge clk);
        check_eq("t1_valid_cnt", vcnt_a - v0, 1);
        check_eq("t1_rx_data", rx_data_a, 8'hA5);
        check_eq("t1_stop_err", stop_err_a, 0);
        check_eq("t1_par_err", par_err_a, 0);

        // 2: 7E2 loopback 0x55, four ones -> even parity bit 0
        v0 = vcnt_b;
        @(negedge clk);
        tx_start_b = 1'b1;
        tx_data_b  = 7'h55;
        @(negedge clk);
        tx_start_b = 1'b0;
        busy_n = 0;
        par_tx = -1;
        while (busy_b && busy_n < 1000) begin
            if (busy_n == 136) par_tx = int'(tx_b);
            busy_n++;
            @(negedge clk);
        end
        check_eq("t2_parity_bit", par_tx, 0);
        check_eq("t2_busy_len", busy_n, 176);
        repeat (5) @(negedge clk);
        check_eq("t2_valid_cnt", vcnt_b - v0, 1);
        check_eq("t2_rx_data", rx_data_b, 7'h55);
        check_eq("t2_stop_err", stop_err_b, 0);
        check_eq("t2_par_err", par_err_b, 0);

        // 3: odd parity; 0x0F has four ones so the correct odd parity bit is 1
        v0 = vcnt_c;
        send_rx(9'h00F, 8, 1'b1, 1'b0, 1'b1);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("t3_valid_cnt", vcnt_c - v0, 1);
        check_eq("t3_rx_data", rx_data_c, 8'h0F);
        check_eq("t3_par_err", par_err_c, 1);
        check_eq("t3_stop_err", stop_err_c, 0);
        send_rx(9'h00F, 8, 1'b1, 1'b1, 1'b1);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("t3b_valid_cnt", vcnt_c - v0, 2);
        check_eq("t3b_par_err", par_err_c, 0);

        // 4: 0x3C with stop bit low, line then stuck low
        loop_a = 1'b0;
        repeat (5) @(negedge clk);
        v0 = vcnt_a;
        send_rx(9'h03C, 8, 1'b0, 1'b0, 1'b0);
        check_eq("t4_valid_cnt", vcnt_a - v0, 1);
        check_eq("t4_stop_err", stop_err_a, 1);
        check_eq("t4_rx_data", rx_data_a, 8'h3C);
        repeat (200) @(negedge clk);
        check_eq("t4_stuck_low_cnt", vcnt_a - v0, 1);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);

        // 5: 4-clock glitch, then a good 0xC3 frame
        v0 = vcnt_a;
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("t5_glitch_cnt", vcnt_a - v0, 0);
        send_rx(9'h0C3, 8, 1'b0, 1'b0, 1'b1);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("t5_valid_cnt", vcnt_a - v0, 1);
        check_eq("t5_rx_data", rx_data_a, 8'hC3);
        check_eq("t5_stop_err", stop_err_a, 0);

        // 6: mid-frame tx_start ignored, then reset mid-frame
        loop_a = 1'b1;
        repeat (5) @(negedge clk);
        v0 = vcnt_a;
        start_a(8'h3A);
        measure_a(50, low_run, busy_n);
        check_eq("t6_busy_len", busy_n, 160);
        repeat (10) @(negedge clk);
        check_eq("t6_busy_after", busy_a, 0);
        check_eq("t6_valid_cnt", vcnt_a - v0, 1);
        check_eq("t6_rx_data", rx_data_a, 8'h3A);
        v0 = vcnt_a;
        start_a(8'h5C);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t6_rst_tx", tx_a, 1);
        check_eq("t6_rst_busy", busy_a, 0);
        check_eq("t6_rst_rx_data", rx_data_a, 0);
        repeat (300) @(negedge clk);
        check_eq("t6_rst_valid_cnt", vcnt_a - v0, 0);
        check_eq("t6_rst_tx_idle", tx_a, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
